cache_lookup_ctrl: RTL and testbench

Lookup and refill controller for the 4-way set-associative cache. It sits directly downstream of the per-line 25-bit tag registers. It consumes the four way tags of the indexed set, detects hit or miss, and owns the valid bits and true-LRU ages. On a miss it runs a memory refill handshake, then drives the tag-register write strobe, the one-hot way select and the new tag back into the tag array.

---
 rtl/cache_lookup_ctrl_if.sv | 33 +++
 rtl/cache_lookup_ctrl.sv | 135 +++++++++++++
 tb/tb_cache_lookup_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_lookup_ctrl_if.sv
// Lookup, response, refill and tag-write signals
// between the cache lookup controller and its neighbours.
interface cache_lookup_ctrl_if #(
   parameter int TAG_W   = 25,
   parameter int INDEX_W = 3
);
   logic               req_valid;
   logic [31:0]        req_addr;
   logic               req_ready;
   logic [INDEX_W-1:0] set_idx;
   logic [4*TAG_W-1:0] tag_q;
   logic               resp_valid;
   logic               resp_hit;
   logic [1:0]         resp_way;
   logic               mem_req;
   logic [31:0]        mem_addr;
   logic               mem_ack;
   logic               tag_we;
   logic [3:0]         way_dec;
   logic [TAG_W-1:0]   tag_d;

   modport master (
      output req_valid, req_addr, tag_q, mem_ack,
      input  req_ready, set_idx, resp_valid, resp_hit, resp_way,
      input  mem_req, mem_addr, tag_we, way_dec, tag_d
   );

   modport slave (
      input  req_valid, req_addr, tag_q, mem_ack,
      output req_ready, set_idx, resp_valid, resp_hit, resp_way,
      output mem_req, mem_addr, tag_we, way_dec, tag_d
   );
endinterface

// File: rtl/cache_lookup_ctrl.sv
// 4-way set-associative lookup/refill controller.
// Owns valid bits and true-LRU ages; tags live outside.
module cache_lookup_ctrl #(
   parameter int NUM_SETS = 8,
   parameter int INDEX_W  = 3,
   parameter int TAG_W    = 25,
   parameter int OFFSET_W = 4
) (
   input logic              clk,
   input logic              reset,
   cache_lookup_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE, LOOKUP, REFILL, WRITE
   } state_t;

   state_t state, state_nxt;

   logic [TAG_W+INDEX_W-1:0] line_q;
   logic [3:0]         valid [NUM_SETS];
   logic [1:0]         age [NUM_SETS][4];
   logic [1:0]         victim_q;
   logic [1:0]         victim;
   logic [1:0]         hit_way;
   logic [3:0]         hit_vec;
   logic               hit;
   logic               acc_en;
   logic [1:0]         acc_way;
   logic [TAG_W-1:0]   tag;
   logic [INDEX_W-1:0] idx;
   logic               unused_offset;

   assign tag = line_q[INDEX_W +: TAG_W];
   assign idx = line_q[INDEX_W-1:0];
   assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

   assign bus.set_idx  = idx;
   assign bus.mem_addr = {line_q, {OFFSET_W{1'b0}}};
   assign bus.tag_d    = tag;

   // Tag compare, lowest hit way, and victim choice
   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      victim  = '0;
      for (int w = 0; w < 4; w++)
         hit_vec[w] = valid[idx][w] &&
            (bus.tag_q[TAG_W*w +: TAG_W] == tag);
      for (int w = 3; w >= 0; w--)
         if (hit_vec[w]) hit_way = 2'(w);
      for (int w = 3; w >= 0; w--)
         if (age[idx][w] == 2'd3) victim = 2'(w);
      for (int w = 3; w >= 0; w--)
         if (!valid[idx][w]) victim = 2'(w);
   end

   assign hit = |hit_vec;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and handshake/response outputs
   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_hit   = 1'b0;
      bus.resp_way   = 2'd0;
      bus.mem_req    = 1'b0;
      bus.tag_we     = 1'b0;
      bus.way_dec    = 4'd0;
      acc_en         = 1'b0;
      acc_way        = victim_q;
      unique case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nxt = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               bus.resp_valid = 1'b1;
               bus.resp_hit   = 1'b1;
               bus.resp_way   = hit_way;
               acc_en         = 1'b1;
               acc_way        = hit_way;
               state_nxt      = IDLE;
            end else begin
               state_nxt = REFILL;
            end
         end
         REFILL: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack) state_nxt = WRITE;
         end
         WRITE: begin
            bus.tag_we     = 1'b1;
            bus.way_dec    = 4'b0001 << victim_q;
            bus.resp_valid = 1'b1;
            bus.resp_way   = victim_q;
            acc_en         = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, victim, valid bits and LRU ages
   always_ff @(posedge clk) begin
      if (reset) begin
         line_q   <= '0;
         victim_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid[s] <= '0;
            for (int w = 0; w < 4; w++)
               age[s][w] <= 2'(w);
         end
      end else begin
         if (state == IDLE && bus.req_valid)
            line_q <= bus.req_addr[31:OFFSET_W];
         if (state == LOOKUP && !hit)
            victim_q <= victim;
         if (state == WRITE)
            valid[idx][victim_q] <= 1'b1;
         if (acc_en) begin
            for (int w = 0; w < 4; w++)
               if (age[idx][w] < age[idx][acc_way])
                  age[idx][w] <= age[idx][w] + 2'd1;
            age[idx][acc_way] <= 2'd0;
         end
      end
   end
endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Scoreboard bench for cache_lookup_ctrl: directed lookups,
// refills, stalls, reset mid-refill and stray acks.
module tb_cache_lookup_ctrl;
   logic clk;
   logic reset;

   cache_lookup_ctrl_if #(.TAG_W(25), .INDEX_W(3)) bus ();

   cache_lookup_ctrl #(
      .NUM_SETS(8), .INDEX_W(3), .TAG_W(25), .OFFSET_W(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        hit;
      logic [1:0]  way;
      logic [24:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [24:0] tmodel [8][4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tag array model: combinational read, written by tag_we
   always_comb begin
      bus.tag_q = '0;
      for (int w = 0; w < 4; w++)
         bus.tag_q[25*w +: 25] = tmodel[bus.set_idx][w];
   end

   always @(posedge clk) begin
      if (bus.tag_we)
         for (int w = 0; w < 4; w++)
            if (bus.way_dec[w])
               tmodel[bus.set_idx][w] <= bus.tag_d;
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h",
                  name, act, req);
      end
   endtask

   // Monitor: pop and compare on every response strobe
   always @(negedge clk) begin
      if (!reset && bus.resp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
            check("resp_way", 32'(bus.resp_way), 32'(e.way));
            if (e.hit) begin
               check("hit_tag_we", 32'(bus.tag_we), 32'd0);
            end else begin
               check("tag_we", 32'(bus.tag_we), 32'd1);
               check("way_dec", 32'(bus.way_dec),
                     32'(4'b0001 << e.way));
               check("tag_d", 32'(bus.tag_d), 32'(e.tag));
            end
         end
      end
      if (!reset && bus.tag_we && !bus.resp_valid)
         check("stray_tag_we", 32'd1, 32'd0);
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 4) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic do_req(input logic [31:0] a,
                         input logic eh,
                         input logic [1:0] ew,
                         input int dly,
                         input logic poke);
      exp_t e;
      logic [31:0] ma;
      int n;
      ma = a & 32'hFFFF_FFF0;
      e.hit = eh;
      e.way = ew;
      e.tag = a[31:7];
      exp_q.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("set_idx", 32'(bus.set_idx), 32'(a[6:4]));
      if (eh) begin
         check("hit_latency", 32'(bus.resp_valid), 32'd1);
         check("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
         @(posedge clk); #1;
      end else begin
         n = 0;
         while (!bus.mem_req && n < 4) begin
            @(posedge clk); #1;
            n++;
         end
         check("mem_req_rise", 32'(bus.mem_req), 32'd1);
         if (bus.mem_req) begin
            for (int i = 0; i < dly; i++) begin
               check("stall_mem_req", 32'(bus.mem_req), 32'd1);
               check("stall_mem_addr", bus.mem_addr, ma);
               check("stall_ready", 32'(bus.req_ready), 32'd0);
               bus.req_valid = poke && (i == 3);
               bus.req_addr  = 32'h0000_0040;
               @(posedge clk); #1;
            end
            bus.req_valid = 1'b0;
            check("mem_addr", bus.mem_addr, ma);
            bus.mem_ack = 1'b1;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            check("write_tag_we", 32'(bus.tag_we), 32'd1);
            @(posedge clk); #1;
         end
      end
      drain();
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.mem_ack   = 1'b0;
      do_reset();

      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
      check("rst_resp_way", 32'(bus.resp_way), 32'd0);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_tag_we", 32'(bus.tag_we), 32'd0);
      check("rst_way_dec", 32'(bus.way_dec), 32'd0);
      check("rst_tag_d", 32'(bus.tag_d), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_set_idx", 32'(bus.set_idx), 32'd0);

      // Cold miss, then hit on same block
      do_req(32'h0000_0020, 1'b0, 2'd0, 3, 1'b0);
      do_req(32'h0000_002C, 1'b1, 2'd0, 0, 1'b0);

      // Fresh set: fill four ways, hit, evict LRU
      do_reset();
      do_req(32'h0000_00A0, 1'b0, 2'd0, 0, 1'b0);
      do_req(32'h0000_0120, 1'b0, 2'd1, 1, 1'b0);
      do_req(32'h0000_01A0, 1'b0, 2'd2, 2, 1'b0);
      do_req(32'h0000_0220, 1'b0, 2'd3, 0, 1'b0);
      do_req(32'h0000_00A0, 1'b1, 2'd0, 0, 1'b0);
      do_req(32'h0000_02A0, 1'b0, 2'd1, 1, 1'b0);

      // Stalled refill with a poked request
      do_req(32'h0000_0320, 1'b0, 2'd2, 10, 1'b1);
      do_req(32'h0000_0220, 1'b1, 2'd3, 0, 1'b0);
      do_req(32'h0000_02A0, 1'b1, 2'd1, 0, 1'b0);

      // Reset while refilling
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0300;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_mem_req", 32'(bus.mem_req), 32'd1);
      check("abort_mem_addr", bus.mem_addr, 32'h0000_0300);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      check("late_ack_tag_we", 32'(bus.tag_we), 32'd0);
      check("late_ack_ready", 32'(bus.req_ready), 32'd1);
      do_req(32'h0000_002C, 1'b0, 2'd0, 1, 1'b0);

      // Stray ack in IDLE
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      check("stray_ready", 32'(bus.req_ready), 32'd1);
      check("stray_mem_req", 32'(bus.mem_req), 32'd0);
      check("stray_tag_we", 32'(bus.tag_we), 32'd0);
      check("stray_resp", 32'(bus.resp_valid), 32'd0);
      check("stray_mem_addr", bus.mem_addr, 32'h0000_0020);
      @(posedge clk); #1;
      check("stray_ready2", 32'(bus.req_ready), 32'd1);
      do_req(32'h0000_0020, 1'b1, 2'd0, 0, 1'b0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
